// File: rtl/p5_fetch_unit_pkg.sv
// Shared definitions for the p5 fetch stage: FSM state encoding and the
// opcode field that identifies a HALT instruction.
package p5_defs;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        IF1       = 3'd1,
        IF2       = 3'd2,
        UPDATE_PC = 3'd3,
        HOLD      = 3'd4,
        HALTED    = 3'd5
    } fetch_state_t;

    localparam logic [2:0] OP_HALT = 3'b111;
    localparam int         OPC_MSB = 15;
    localparam int         OPC_LSB = 13;

    // True when the opcode field of an instruction word encodes HALT.
    function automatic logic is_halt_op(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/p5_fetch_unit_pc_reg.sv
// Program counter register. Loads either its own successor or a branch
// target, and exposes the wrapped successor combinationally.
module p5_pc_reg #(
    parameter int                ADDR_W   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              sel_branch,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc
);

    assign pc_inc = pc + ADDR_W'(1);

    // PC update: hold unless loaded, then take the branch target or pc+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= sel_branch ? branch_target : pc_inc;
        end
    end

endmodule

// File: rtl/p5_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory, and
// presents the fetched word to the CPU over a valid/ready handshake.
module p5_fetch_unit
    import p5_defs::*;
#(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_next,
    output logic              halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              pc_load;
    logic              pc_sel_branch;
    logic              handshake;
    logic              ir_is_halt;

    assign mem_addr   = pc;
    assign handshake  = (state == HOLD) && ir_ready;
    assign ir_is_halt = is_halt_op(ir_out[15:0]);

    // PC loads: sequential advance after capture, or a redirect on an accepted non-HALT word.
    always_comb begin
        pc_load       = 1'b0;
        pc_sel_branch = 1'b0;
        if (state == UPDATE_PC) begin
            pc_load = 1'b1;
        end else if (handshake && !ir_is_halt && branch_en) begin
            pc_load       = 1'b1;
            pc_sel_branch = 1'b1;
        end
    end

    p5_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset_n       (reset_n),
        .load          (pc_load),
        .sel_branch    (pc_sel_branch),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_inc        (pc_inc)
    );

    // Fetch sequencer; every output flag is set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RESET;
            ir_out   <= '0;
            mem_rd   <= 1'b0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            pc_next  <= '0;
        end else begin
            case (state)
                RESET: begin
                    state  <= IF1;
                    mem_rd <= 1'b1;
                end
                IF1: begin
                    state  <= IF2;
                    mem_rd <= 1'b1;
                end
                IF2: begin
                    if (mem_ready) begin
                        ir_out <= mem_rdata;
                        mem_rd <= 1'b0;
                        state  <= UPDATE_PC;
                    end
                end
                UPDATE_PC: begin
                    pc_next  <= pc_inc;
                    ir_valid <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        if (ir_is_halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            mem_rd <= 1'b1;
                            state  <= IF1;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state    <= RESET;
                    mem_rd   <= 1'b0;
                    ir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p5_fetch_unit.sv
// Self-checking bench for p5_fetch_unit: a transaction-level fetch model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_p5_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        branch_en;
    logic [8:0]  branch_target;
    logic [8:0]  pc_next;
    logic        halted;

    logic [15:0] memArr [0:511];

    int testCount = 0;
    int failCount = 0;

    p5_fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .ir_out        (ir_out),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .pc_next       (pc_next),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: combinational read of whatever address is presented.
    assign mem_rdata = memArr[mem_addr];

    // Model state, in fetch-transaction terms rather than FSM states.
    logic        m_started;
    logic        m_reqOn;
    int          m_reqAge;
    logic        m_bookkeep;
    logic        m_present;
    logic        m_halt;
    logic [8:0]  m_pc;
    logic [8:0]  m_cur;
    logic [15:0] m_ir;

    // Model: a request needs at least two cycles before data can land; after
    // capture one cycle advances the PC, then the word is offered until taken.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_started  <= 1'b0;
            m_reqOn    <= 1'b0;
            m_reqAge   <= 0;
            m_bookkeep <= 1'b0;
            m_present  <= 1'b0;
            m_halt     <= 1'b0;
            m_pc       <= 9'd0;
            m_cur      <= 9'd0;
            m_ir       <= 16'd0;
        end else if (m_halt) begin
            m_halt <= 1'b1;
        end else if (m_present) begin
            if (ir_ready) begin
                m_present <= 1'b0;
                if (m_ir[15:13] == 3'b111) begin
                    m_halt <= 1'b1;
                end else begin
                    if (branch_en) m_pc <= branch_target;
                    m_reqOn  <= 1'b1;
                    m_reqAge <= 0;
                end
            end
        end else if (m_bookkeep) begin
            m_bookkeep <= 1'b0;
            m_cur      <= m_pc;
            m_pc       <= 9'((int'(m_pc) + 1) % 512);
            m_present  <= 1'b1;
        end else if (m_reqOn) begin
            if (m_reqAge >= 1 && mem_ready) begin
                m_ir       <= memArr[m_pc];
                m_reqOn    <= 1'b0;
                m_bookkeep <= 1'b1;
            end else begin
                m_reqAge <= m_reqAge + 1;
            end
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_reqOn   <= 1'b1;
            m_reqAge  <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on the falling edge.
    always @(negedge clk) begin
        checkOutput("model mem_rd", 32'(mem_rd), 32'(m_reqOn));
        if (m_reqOn) checkOutput("model mem_addr", 32'(mem_addr), 32'(m_pc));
        checkOutput("model ir_valid", 32'(ir_valid), 32'(m_present));
        checkOutput("model ir_out", 32'(ir_out), 32'(m_ir));
        checkOutput("model halted", 32'(halted), 32'(m_halt));
        if (m_present) checkOutput("model pc_next", 32'(pc_next), 32'((int'(m_cur) + 1) % 512));
    end

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic br, input logic [8:0] tgt);
        ir_ready      = 1'b1;
        branch_en     = br;
        branch_target = tgt;
        stepCycles(1);
        ir_ready      = 1'b0;
        branch_en     = 1'b0;
    endtask

    task automatic waitValid(input int budget);
        int n;
        n = 0;
        while (!ir_valid && n < budget) begin
            stepCycles(1);
            n++;
        end
        if (!ir_valid) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL wait ir_valid: got 0, expected 1 within %0d cycles", budget);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) memArr[i] = 16'h1000 | 16'(i);
        memArr[0]     = 16'hD105;
        memArr[9'h020] = 16'h4A21;
        memArr[9'h1FF] = 16'h2BCD;
        memArr[9'h050] = 16'hE000;

        reset_n       = 1'b0;
        mem_ready     = 1'b1;
        ir_ready      = 1'b0;
        branch_en     = 1'b0;
        branch_target = 9'd0;

        stepCycles(3);
        checkOutput("reset mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("reset ir_out", 32'(ir_out), 32'd0);
        checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;

        // First fetch after reset release.
        stepCycles(1);
        checkOutput("first rd", 32'(mem_rd), 32'd1);
        checkOutput("first addr", 32'(mem_addr), 32'd0);
        stepCycles(2);
        checkOutput("valid before 4th edge", 32'(ir_valid), 32'd0);
        stepCycles(1);
        checkOutput("valid at 4th edge", 32'(ir_valid), 32'd1);
        checkOutput("first ir_out", 32'(ir_out), 32'hD105);
        checkOutput("first pc_next", 32'(pc_next), 32'd1);

        // CPU stalls in HOLD, then branches to 0x020 while memory stalls.
        stepCycles(10);
        checkOutput("hold ir_out", 32'(ir_out), 32'hD105);
        checkOutput("hold no rd", 32'(mem_rd), 32'd0);
        mem_ready = 1'b0;
        applyStimulus(1'b1, 9'h020);
        checkOutput("branch addr", 32'(mem_addr), 32'h020);
        checkOutput("branch rd", 32'(mem_rd), 32'd1);
        stepCycles(6);
        checkOutput("stall rd", 32'(mem_rd), 32'd1);
        checkOutput("stall addr", 32'(mem_addr), 32'h020);
        checkOutput("stall valid", 32'(ir_valid), 32'd0);
        mem_ready = 1'b1;
        stepCycles(1);
        checkOutput("stall capture", 32'(ir_out), 32'h4A21);
        checkOutput("stall rd drop", 32'(mem_rd), 32'd0);
        stepCycles(1);
        checkOutput("stall valid", 32'(ir_valid), 32'd1);
        checkOutput("stall pc_next", 32'(pc_next), 32'h021);

        // PC wrap at the top of the address space.
        applyStimulus(1'b1, 9'h1FF);
        waitValid(40);
        checkOutput("wrap ir_out", 32'(ir_out), 32'h2BCD);
        checkOutput("wrap pc_next", 32'(pc_next), 32'h000);
        applyStimulus(1'b0, 9'h000);
        checkOutput("wrap addr", 32'(mem_addr), 32'h000);
        waitValid(40);
        checkOutput("wrap refetch", 32'(ir_out), 32'hD105);

        // HALT accepted together with a branch request.
        applyStimulus(1'b1, 9'h050);
        waitValid(40);
        checkOutput("halt word", 32'(ir_out), 32'hE000);
        applyStimulus(1'b1, 9'h123);
        checkOutput("halted set", 32'(halted), 32'd1);
        checkOutput("halted valid", 32'(ir_valid), 32'd0);
        stepCycles(6);
        checkOutput("halted no rd", 32'(mem_rd), 32'd0);
        checkOutput("halted pc", 32'(mem_addr), 32'h051);

        // Reset pulse restarts fetch at the reset PC.
        #1 reset_n = 1'b0;
        #1 checkOutput("pulse halted clr", 32'(halted), 32'd0);
        stepCycles(1);
        reset_n = 1'b1;
        stepCycles(1);
        checkOutput("restart rd", 32'(mem_rd), 32'd1);
        checkOutput("restart addr", 32'(mem_addr), 32'd0);
        waitValid(40);
        checkOutput("restart ir_out", 32'(ir_out), 32'hD105);

        // Reset during a stalled IF2 drops the request immediately.
        mem_ready = 1'b0;
        applyStimulus(1'b0, 9'h000);
        stepCycles(2);
        checkOutput("mid rd", 32'(mem_rd), 32'd1);
        checkOutput("mid addr", 32'(mem_addr), 32'd1);
        #1 reset_n = 1'b0;
        #1 checkOutput("async rd drop", 32'(mem_rd), 32'd0);
        checkOutput("async ir clr", 32'(ir_out), 32'd0);
        mem_ready = 1'b1;
        stepCycles(1);
        reset_n = 1'b1;
        stepCycles(1);
        checkOutput("post addr", 32'(mem_addr), 32'd0);
        checkOutput("post ir_out", 32'(ir_out), 32'd0);
        waitValid(40);
        checkOutput("post capture", 32'(ir_out), 32'hD105);

        stepCycles(2);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
